// File: rtl/lbus_arbiter.sv
// rtl/lbus_arbiter.sv - two-master local bus arbiter with lock, round-robin and read-return path
module lbus_arbiter #(
    parameter int XLEN     = 32,
    parameter int MAX_LOCK = 8
) (
    input  logic            clk,
    input  logic            rst,

    input  logic            m0_req,
    input  logic            m0_lock,
    input  logic [XLEN-1:0] m0_addr,
    input  logic [XLEN-1:0] m0_wdata,
    input  logic [3:0]      m0_we,
    output logic            m0_gnt,
    output logic [XLEN-1:0] m0_rdata,
    output logic            m0_rvalid,

    input  logic            m1_req,
    input  logic            m1_lock,
    input  logic [XLEN-1:0] m1_addr,
    input  logic [XLEN-1:0] m1_wdata,
    input  logic [3:0]      m1_we,
    output logic            m1_gnt,
    output logic [XLEN-1:0] m1_rdata,
    output logic            m1_rvalid,

    output logic [XLEN-1:0] bus_addr,
    output logic [XLEN-1:0] bus_qin,
    output logic [3:0]      bus_we,
    input  logic [XLEN-1:0] bus_qout
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_OWN0 = 2'd1;
    localparam logic [1:0] ST_OWN1 = 2'd2;
    localparam logic [7:0] MAX_CNT = 8'(MAX_LOCK);

    logic [1:0] state_q, state_d;
    logic       rr_ptr_q, rr_ptr_d;
    logic [7:0] lock_cnt_q, lock_cnt_d;
    logic       lock_q, lock_d;
    logic       m0_rvalid_q, m0_rvalid_d;
    logic       m1_rvalid_q, m1_rvalid_d;

    logic own0, own1, gnt0, gnt1, lock_hold, forced_release, same_owner;

    assign own0           = (state_q == ST_OWN0);
    assign own1           = (state_q == ST_OWN1);
    assign lock_hold      = (lock_cnt_q < MAX_CNT);
    assign forced_release = lock_q && !lock_hold;

    // Lock keeps ownership until the saturated counter forces a hand-over to the waiting master.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (rst) begin
            gnt0 = 1'b0;
            gnt1 = 1'b0;
        end else if (own0 && lock_q && m0_req && (!m1_req || lock_hold)) begin
            gnt0 = 1'b1;
        end else if (own1 && lock_q && m1_req && (!m0_req || lock_hold)) begin
            gnt1 = 1'b1;
        end else if (m0_req && m1_req) begin
            if (forced_release && own0) begin
                gnt1 = 1'b1;
            end else if (forced_release && own1) begin
                gnt0 = 1'b1;
            end else if (rr_ptr_q) begin
                gnt1 = 1'b1;
            end else begin
                gnt0 = 1'b1;
            end
        end else begin
            gnt0 = m0_req;
            gnt1 = m1_req;
        end
    end

    assign same_owner = (gnt0 && own0) || (gnt1 && own1);

    always_comb begin
        state_d     = ST_IDLE;
        rr_ptr_d    = rr_ptr_q;
        lock_cnt_d  = 8'd0;
        lock_d      = 1'b0;
        m0_rvalid_d = gnt0 && (m0_we == 4'b0000);
        m1_rvalid_d = gnt1 && (m1_we == 4'b0000);
        if (gnt0) begin
            state_d  = ST_OWN0;
            rr_ptr_d = 1'b1;
            lock_d   = m0_lock;
        end else if (gnt1) begin
            state_d  = ST_OWN1;
            rr_ptr_d = 1'b0;
            lock_d   = m1_lock;
        end
        if (gnt0 || gnt1) begin
            if (!same_owner) begin
                lock_cnt_d = 8'd1;
            end else if (lock_hold) begin
                lock_cnt_d = lock_cnt_q + 8'd1;
            end else begin
                lock_cnt_d = MAX_CNT;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            rr_ptr_q    <= 1'b0;
            lock_cnt_q  <= 8'd0;
            lock_q      <= 1'b0;
            m0_rvalid_q <= 1'b0;
            m1_rvalid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            lock_cnt_q  <= lock_cnt_d;
            lock_q      <= lock_d;
            m0_rvalid_q <= m0_rvalid_d;
            m1_rvalid_q <= m1_rvalid_d;
        end
    end

    assign m0_gnt    = gnt0;
    assign m1_gnt    = gnt1;
    assign m0_rvalid = m0_rvalid_q;
    assign m1_rvalid = m1_rvalid_q;
    assign m0_rdata  = m0_rvalid_q ? bus_qout : '0;
    assign m1_rdata  = m1_rvalid_q ? bus_qout : '0;

    assign bus_addr = gnt0 ? m0_addr  : (gnt1 ? m1_addr  : '0);
    assign bus_qin  = gnt0 ? m0_wdata : (gnt1 ? m1_wdata : '0);
    assign bus_we   = gnt0 ? m0_we    : (gnt1 ? m1_we    : 4'b0000);

endmodule

// File: tb/tb_lbus_arbiter.sv
// tb/tb_lbus_arbiter.sv - self-checking bench for lbus_arbiter with a synchronous RAM model
module tb_lbus_arbiter;

    localparam int XLEN     = 32;
    localparam int MAX_LOCK = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic            m0_req, m0_lock, m1_req, m1_lock;
    logic [XLEN-1:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic [3:0]      m0_we, m1_we;
    logic            m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
    logic [XLEN-1:0] m0_rdata, m1_rdata;
    logic [XLEN-1:0] bus_addr, bus_qin, bus_qout;
    logic [3:0]      bus_we;

    int pass_cnt = 0;
    int total    = 0;

    logic [31:0] mem [0:255];

    always #5 clk = ~clk;

    lbus_arbiter #(.XLEN(XLEN), .MAX_LOCK(MAX_LOCK)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_lock(m0_lock), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_we(m0_we), .m0_gnt(m0_gnt), .m0_rdata(m0_rdata), .m0_rvalid(m0_rvalid),
        .m1_req(m1_req), .m1_lock(m1_lock), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_we(m1_we), .m1_gnt(m1_gnt), .m1_rdata(m1_rdata), .m1_rvalid(m1_rvalid),
        .bus_addr(bus_addr), .bus_qin(bus_qin), .bus_we(bus_we), .bus_qout(bus_qout)
    );

    // Synchronous RAM, word-addressed by bus_addr[9:2]; refilled with a known pattern during reset.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'hA5000000 ^ (i * 32'h00010203);
        end else begin
            for (int b = 0; b < 4; b++)
                if (bus_we[b]) mem[bus_addr[9:2]][b*8 +: 8] <= bus_qin[b*8 +: 8];
        end
        bus_qout <= mem[bus_addr[9:2]];
    end

    // Reference arbitration state: owner (-1 = none), lock history, consecutive count, rr pointer.
    int  ref_own, ref_cnt, ref_rr;
    bit  ref_hist;

    task automatic model_reset();
        ref_own = -1; ref_cnt = 0; ref_rr = 0; ref_hist = 0;
    endtask

    task automatic model_step(input bit r0, input bit l0, input bit r1, input bit l1, output int g);
        bit r[2];
        bit l[2];
        r[0] = r0; r[1] = r1; l[0] = l0; l[1] = l1;
        g = -1;
        if (ref_own >= 0 && ref_hist && r[ref_own] && (!r[1-ref_own] || ref_cnt < MAX_LOCK))
            g = ref_own;
        else if (r0 && r1)
            g = (ref_own >= 0 && ref_hist && ref_cnt >= MAX_LOCK) ? 1 - ref_own : ref_rr;
        else if (r0)
            g = 0;
        else if (r1)
            g = 1;
        if (g >= 0) begin
            ref_cnt  = (g == ref_own) ? ((ref_cnt + 1 > MAX_LOCK) ? MAX_LOCK : ref_cnt + 1) : 1;
            ref_rr   = 1 - g;
            ref_hist = l[g];
            ref_own  = g;
        end else begin
            ref_own  = -1;
            ref_hist = 0;
            ref_cnt  = 0;
        end
    endtask

    task automatic clear_inputs();
        m0_req = 0; m0_lock = 0; m0_addr = 0; m0_wdata = 0; m0_we = 0;
        m1_req = 0; m1_lock = 0; m1_addr = 0; m1_wdata = 0; m1_we = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1;
        clear_inputs();
        repeat (2) @(negedge clk);
        rst = 0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1;
        m0_req = 1; m1_req = 1; m0_we = 4'hF; m1_we = 4'h3;
        m0_addr = 32'h10; m1_addr = 32'h20;
        #1;
        total++; if ({m0_gnt, m1_gnt} !== 2'b00) $display("FAIL reset_gnt: got %b expected 00", {m0_gnt, m1_gnt}); else pass_cnt++;
        total++; if (bus_we !== 4'b0000) $display("FAIL reset_bus_we: got %h expected 0", bus_we); else pass_cnt++;
        total++; if (bus_addr !== 32'h0) $display("FAIL reset_bus_addr: got %h expected 0", bus_addr); else pass_cnt++;
        @(negedge clk);
        total++; if ({m0_rvalid, m1_rvalid} !== 2'b00) $display("FAIL reset_rvalid: got %b expected 00", {m0_rvalid, m1_rvalid}); else pass_cnt++;
        total++; if (m0_rdata !== 32'h0) $display("FAIL reset_rdata: got %h expected 0", m0_rdata); else pass_cnt++;
        clear_inputs();
    endtask

    task automatic test_rr_reads();
        logic [31:0] a, b;
        do_reset();
        a = mem[64]; b = mem[128];
        m0_req = 1; m0_addr = 32'h100; m1_req = 1; m1_addr = 32'h200;
        #1;
        total++; if ({m0_gnt, m1_gnt} !== 2'b10) $display("FAIL rr_cycle0_gnt: got %b expected 10", {m0_gnt, m1_gnt}); else pass_cnt++;
        total++; if (bus_addr !== 32'h100) $display("FAIL rr_cycle0_addr: got %h expected 100", bus_addr); else pass_cnt++;
        @(negedge clk);
        m0_req = 0;
        #1;
        total++; if ({m0_gnt, m1_gnt} !== 2'b01) $display("FAIL rr_cycle1_gnt: got %b expected 01", {m0_gnt, m1_gnt}); else pass_cnt++;
        total++; if (m0_rvalid !== 1'b1 || m0_rdata !== a) $display("FAIL rr_m0_read: got v=%b d=%h expected v=1 d=%h", m0_rvalid, m0_rdata, a); else pass_cnt++;
        @(negedge clk);
        m1_req = 0;
        #1;
        total++; if (m1_rvalid !== 1'b1 || m1_rdata !== b) $display("FAIL rr_m1_read: got v=%b d=%h expected v=1 d=%h", m1_rvalid, m1_rdata, b); else pass_cnt++;
        total++; if (m0_rvalid !== 1'b0) $display("FAIL rr_m0_rvalid_drop: got %b expected 0", m0_rvalid); else pass_cnt++;
        @(negedge clk);
    endtask

    task automatic test_alternate();
        do_reset();
        m0_req = 1; m1_req = 1; m0_addr = 32'h4; m1_addr = 32'h8;
        for (int i = 0; i < 8; i++) begin
            #1;
            total++;
            if ({m0_gnt, m1_gnt} !== ((i % 2 == 0) ? 2'b10 : 2'b01))
                $display("FAIL alternate_%0d: got %b expected %b", i, {m0_gnt, m1_gnt}, (i % 2 == 0) ? 2'b10 : 2'b01);
            else pass_cnt++;
            @(negedge clk);
        end
        clear_inputs();
    endtask

    task automatic test_lock();
        logic [1:0] exp;
        do_reset();
        m1_req = 1; m1_lock = 1; m1_addr = 32'h30; m0_addr = 32'h50;
        for (int c = 0; c < 10; c++) begin
            m0_req = (c >= 2);
            #1;
            exp = (c <= 7 || c == 9) ? 2'b01 : 2'b10;
            total++;
            if ({m0_gnt, m1_gnt} !== exp) $display("FAIL lock_cycle_%0d: got %b expected %b", c, {m0_gnt, m1_gnt}, exp);
            else pass_cnt++;
            @(negedge clk);
        end
        clear_inputs();
    endtask

    task automatic test_write_read();
        do_reset();
        m0_req = 1; m0_we = 4'hF; m0_wdata = 32'hDEADBEEF; m0_addr = 32'h40;
        #1;
        total++; if (m0_gnt !== 1'b1 || bus_we !== 4'hF || bus_qin !== 32'hDEADBEEF)
            $display("FAIL wr_bus: got g=%b we=%h q=%h expected g=1 we=f q=deadbeef", m0_gnt, bus_we, bus_qin); else pass_cnt++;
        @(negedge clk);
        clear_inputs();
        m1_req = 1; m1_addr = 32'h40;
        #1;
        total++; if (m1_gnt !== 1'b1 || bus_we !== 4'h0) $display("FAIL wr_then_rd_bus: got g=%b we=%h expected g=1 we=0", m1_gnt, bus_we); else pass_cnt++;
        total++; if (m0_rvalid !== 1'b0) $display("FAIL wr_no_rvalid: got %b expected 0", m0_rvalid); else pass_cnt++;
        @(negedge clk);
        m1_req = 0;
        #1;
        total++; if (m1_rvalid !== 1'b1 || m1_rdata !== 32'hDEADBEEF)
            $display("FAIL wr_readback: got v=%b d=%h expected v=1 d=deadbeef", m1_rvalid, m1_rdata); else pass_cnt++;
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        do_reset();
        m1_req = 1; m1_addr = 32'h84;
        #1;
        total++; if (m1_gnt !== 1'b1) $display("FAIL rstmid_pre_gnt: got %b expected 1", m1_gnt); else pass_cnt++;
        #2;
        rst = 1;
        #1;
        total++; if ({m0_gnt, m1_gnt} !== 2'b00 || bus_we !== 4'h0 || bus_addr !== 32'h0)
            $display("FAIL rstmid_outputs: got g=%b we=%h a=%h expected zeros", {m0_gnt, m1_gnt}, bus_we, bus_addr); else pass_cnt++;
        @(negedge clk);
        total++; if (m1_rvalid !== 1'b0 || m1_rdata !== 32'h0)
            $display("FAIL rstmid_rvalid: got v=%b d=%h expected 0", m1_rvalid, m1_rdata); else pass_cnt++;
        rst = 0;
        m0_req = 1;
        #1;
        total++; if ({m0_gnt, m1_gnt} !== 2'b10) $display("FAIL rstmid_contention: got %b expected 10", {m0_gnt, m1_gnt}); else pass_cnt++;
        @(negedge clk);
        clear_inputs();
    endtask

    task automatic test_single();
        do_reset();
        for (int i = 0; i < 12; i++) begin
            m0_req = (i < 6); m1_req = (i >= 6);
            m0_addr = {22'd0, 8'($urandom), 2'b00};
            m1_addr = {22'd0, 8'($urandom), 2'b00};
            #1;
            total++;
            if ((i < 6) ? (m0_gnt !== 1'b1 || m1_gnt !== 1'b0 || bus_addr !== m0_addr)
                        : (m1_gnt !== 1'b1 || m0_gnt !== 1'b0 || bus_addr !== m1_addr))
                $display("FAIL single_%0d: got g=%b a=%h expected owner=%0d", i, {m0_gnt, m1_gnt}, bus_addr, (i < 6) ? 0 : 1);
            else pass_cnt++;
            @(negedge clk);
        end
        clear_inputs();
    endtask

    task automatic test_random();
        int          g, prev_g;
        bit          exp_rv0, exp_rv1;
        logic [31:0] exp_rd, exp_addr;
        do_reset();
        model_reset();
        prev_g = -1; exp_rv0 = 0; exp_rv1 = 0; exp_rd = 0;
        for (int c = 0; c < 400; c++) begin
            total++;
            if (m0_rvalid !== exp_rv0 || m1_rvalid !== exp_rv1)
                $display("FAIL rand_rvalid_%0d: got %b%b expected %b%b", c, m0_rvalid, m1_rvalid, exp_rv0, exp_rv1);
            else pass_cnt++;
            if (exp_rv0 || exp_rv1) begin
                total++;
                if ((exp_rv0 ? m0_rdata : m1_rdata) !== exp_rd)
                    $display("FAIL rand_rdata_%0d: got %h expected %h", c, exp_rv0 ? m0_rdata : m1_rdata, exp_rd);
                else pass_cnt++;
            end
            if (!(m0_req && prev_g != 0)) begin
                m0_req = ($urandom_range(0, 9) < 8); m0_lock = ($urandom_range(0, 9) < 7);
                m0_addr = {22'd0, 8'($urandom), 2'b00}; m0_wdata = $urandom;
                m0_we = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
            end
            if (!(m1_req && prev_g != 1)) begin
                m1_req = ($urandom_range(0, 9) < 8); m1_lock = ($urandom_range(0, 9) < 7);
                m1_addr = {22'd0, 8'($urandom), 2'b00}; m1_wdata = $urandom;
                m1_we = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
            end
            #1;
            model_step(m0_req, m0_lock, m1_req, m1_lock, g);
            exp_addr = (g == 0) ? m0_addr : ((g == 1) ? m1_addr : 32'h0);
            total++;
            if (m0_gnt !== (g == 0) || m1_gnt !== (g == 1) || bus_addr !== exp_addr)
                $display("FAIL rand_gnt_%0d: got g=%b a=%h expected owner=%0d a=%h", c, {m0_gnt, m1_gnt}, bus_addr, g, exp_addr);
            else pass_cnt++;
            exp_rv0 = (g == 0) && (m0_we == 4'h0);
            exp_rv1 = (g == 1) && (m1_we == 4'h0);
            exp_rd  = mem[exp_addr[9:2]];
            prev_g  = g;
            @(negedge clk);
        end
        clear_inputs();
    endtask

    initial begin
        rst = 1;
        clear_inputs();
        test_reset();
        test_rr_reads();
        test_alternate();
        test_lock();
        test_write_read();
        test_reset_mid();
        test_single();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule

// File: doc/lbus_arbiter.md
LBUS_ARBITER -- requirements
Module: lbus_arbiter

Interface
REQ-001 Parameter XLEN, default 32, data/address width of masters and local bus.
REQ-002 Parameter MAX_LOCK, default 8, max consecutive locked grants to one master while the other is requesting (range 2..255).
REQ-003 clk  input  1  global clock; all state on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 m0_req  input  1  master 0 (CPU data port) access request, held until granted.
REQ-006 m0_lock  input  1  master 0 requests to keep ownership on the next cycle.
REQ-007 m0_addr  input  XLEN  master 0 byte address.
REQ-008 m0_wdata  input  XLEN  master 0 write data.
REQ-009 m0_we  input  4  master 0 byte write enables; 0000 = read.
REQ-010 m0_gnt  output  1  access accepted this cycle (combinational).
REQ-011 m0_rdata  output  XLEN  read data, valid when m0_rvalid=1.
REQ-012 m0_rvalid  output  1  registered; high the cycle after a granted read.
REQ-013 m1_req, m1_lock, m1_addr, m1_wdata, m1_we, m1_gnt, m1_rdata, m1_rvalid: same widths and meaning for master 1 (DMA).
REQ-014 bus_addr  output  XLEN  local bus address.
REQ-015 bus_qin  output  XLEN  local bus write data.
REQ-016 bus_we  output  4  local bus write enables.
REQ-017 bus_qout  input  XLEN  local bus read data; valid one cycle after address (synchronous RAM).

Function
REQ-018 At most one of m0_gnt/m1_gnt SHALL be high in any cycle; gnt only when the matching req is high.
REQ-019 Granted master's addr/wdata/we SHALL drive bus_* combinationally in the grant cycle; with no grant, bus_addr=0, bus_qin=0, bus_we=0000.
REQ-020 Each grant completes one access; a master holding req after gnt receives a new arbitration next cycle.
REQ-021 State SHALL be IDLE (no grant last cycle), OWN0 or OWN1 (last cycle granted master 0/1); registered.
REQ-022 Lock rule: in OWNx, if mx_req & mx_lock were high in the previous grant cycle and mx_req is high now, grant x if the other master is not requesting or lock_cnt < MAX_LOCK.
REQ-023 Otherwise round-robin: one requester -> grant it; both -> grant master indicated by rr_ptr.
REQ-024 rr_ptr SHALL update to the non-granted master after every grant; unchanged in cycles without grant.
REQ-025 lock_cnt (8 bit) SHALL be 1 on a grant to a master different from the previous cycle's grantee or following an idle cycle, increment on consecutive grants to the same master, saturate at MAX_LOCK.
REQ-026 On forced release at lock_cnt == MAX_LOCK with both requesting, the other master SHALL be granted regardless of rr_ptr.
REQ-027 mx_rvalid SHALL be high exactly one cycle after a grant with mx_we == 0000; writes produce no rvalid.
REQ-028 mx_rdata SHALL equal bus_qout while mx_rvalid=1, else 0.
REQ-029 Back-to-back reads from different masters SHALL each return their own data on consecutive cycles with no bubble.

Reset
REQ-030 On rst high (asynchronous): state=IDLE, rr_ptr=master 0, lock_cnt=0, m0_rvalid=m1_rvalid=0, lock history cleared.
REQ-031 During rst, gnt outputs SHALL be 0 and bus_we=0000; a read granted in the cycle rst asserts SHALL NOT produce rvalid.
REQ-032 First arbitration after rst release SHALL favour master 0 on contention.

Verification
REQ-033 After reset, m0_req=m1_req=1 reads, addr 0x100/0x200 -> m0_gnt cycle 0, m1_gnt cycle 1, m0_rvalid cycle 1, m1_rvalid cycle 2 with respective RAM data.
REQ-034 Both requesting continuously, no lock -> grants alternate 0,1,0,1 for 8 cycles.
REQ-035 m1_req+m1_lock held, m0_req raised at cycle 2, MAX_LOCK=8 -> m1 granted through lock_cnt=8, then m0 granted next cycle.
REQ-036 m0 write we=1111 data 0xDEADBEEF at 0x40, then m1 read 0x40 -> bus_we=1111 one cycle, no rvalid for write, m1_rdata=0xDEADBEEF.
REQ-037 rst asserted mid-cycle during m1 read grant -> outputs zero immediately, no m1_rvalid, next contention grants m0.
REQ-038 Single master requesting each cycle, other idle -> grant every cycle, bus never driven by idle master.
